// File: rtl/pipeline_mac_accumulator_module_if.sv
// Handshake bundle between the LUT multiplier side and the MAC accumulator.
// The master side drives the operand qualifiers and product; the slave side returns the frame sum.
interface pipeline_mac_accumulator_module_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_last;
  logic             acc_clear;
  logic [15:0]      product;
  logic [ACC_W-1:0] sum_o;
  logic             sum_valid_o;
  logic             overflow_o;
  logic             busy_o;

  modport master (
    output in_valid, in_last, acc_clear, product,
    input  sum_o, sum_valid_o, overflow_o, busy_o
  );

  modport slave (
    input  in_valid, in_last, acc_clear, product,
    output sum_o, sum_valid_o, overflow_o, busy_o
  );
endinterface

// File: rtl/pipeline_mac_accumulator_module.sv
// Accumulates multiplier products into per-frame dot-product sums, with a valid/last
// delay line matched to the multiplier latency and a sticky per-frame overflow flag.
//
// state | meaning
// IDLE  | no partial frame held (cnt == 0)
// ACC   | partial frame accumulating, waiting for last or the LEN-th product
module pipeline_mac_accumulator_module #(
  parameter int LATENCY = 3,
  parameter int LEN     = 8,
  parameter int ACC_W   = 24
) (
  input logic                             clk,
  input logic                             rst_n,
  pipeline_mac_accumulator_module_if.slave bus
);
  localparam int CNT_W = $clog2(LEN);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [LATENCY-1:0] v_line, l_line;
  logic             dv, dl, frame_end, fovf;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] acc, acc_nxt, sum_reg, sum_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             sum_ovf, sum_ovf_nxt;
  logic             strobe, strobe_nxt;

  // Side-band delay line; a clear flushes every stage including the one sampled now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_line <= '0;
      l_line <= '0;
    end else if (bus.acc_clear) begin
      v_line <= '0;
      l_line <= '0;
    end else begin
      v_line[0] <= bus.in_valid;
      l_line[0] <= bus.in_valid & bus.in_last;
      for (int i = 1; i < LATENCY; i++) begin
        v_line[i] <= v_line[i-1];
        l_line[i] <= l_line[i-1];
      end
    end
  end

  assign dv        = v_line[LATENCY-1];
  assign dl        = l_line[LATENCY-1];
  assign nxt       = {1'b0, acc} + {{(ACC_W-15){1'b0}}, bus.product};
  assign fovf      = ovf | nxt[ACC_W];
  assign frame_end = dv & (dl | (cnt == CNT_W'(LEN-1)));

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    sum_nxt     = sum_reg;
    sum_ovf_nxt = sum_ovf;
    strobe_nxt  = 1'b0;
    if (bus.acc_clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (frame_end) begin
      sum_nxt     = nxt[ACC_W-1:0];
      sum_ovf_nxt = fovf;
      strobe_nxt  = 1'b1;
      state_nxt   = IDLE;
      acc_nxt     = '0;
      cnt_nxt     = '0;
      ovf_nxt     = 1'b0;
    end else if (dv) begin
      state_nxt = ACC;
      acc_nxt   = nxt[ACC_W-1:0];
      cnt_nxt   = cnt + CNT_W'(1);
      ovf_nxt   = fovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_reg <= '0;
      sum_ovf <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      sum_reg <= sum_nxt;
      sum_ovf <= sum_ovf_nxt;
      strobe  <= strobe_nxt;
    end
  end

  assign bus.sum_o       = sum_reg;
  assign bus.sum_valid_o = strobe;
  assign bus.overflow_o  = sum_ovf;
  assign bus.busy_o      = (state == ACC) | (|v_line);
endmodule

// File: tb/tb_pipeline_mac_accumulator_module.sv
// Bench for the MAC accumulator: a behavioural 8x8 multiplier feeds it, and a frame-level
// model (plain integer sums per frame) is compared against the outputs on every edge.
module tb_pipeline_mac_accumulator_module;
  localparam int    LAT   = 3;
  localparam int    LEN   = 8;
  localparam int    ACC_W = 16;
  localparam longint MODV = longint'(1) << ACC_W;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in, b_in;
  logic [15:0] mpipe [LAT];

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  pipeline_mac_accumulator_module_if #(.ACC_W(ACC_W)) bus ();

  pipeline_mac_accumulator_module #(.LATENCY(LAT), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the pipelined multiplier: product lines up LAT edges after a/b.
  always @(posedge clk) begin
    mpipe[0] <= a_in * b_in;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.product = mpipe[LAT-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [7:0] ai, input logic [7:0] bi,
                       input logic clr);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_last   = l;
    a_in          = ai;
    b_in          = bi;
    bus.acc_clear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  // Frame-level model: a pair sampled at edge s lands at edge s+LAT unless a clear or
  // reset was seen at some edge s..s+LAT; frames sum with unbounded integers.
  logic   rec_v [0:1023];
  logic   rec_l [0:1023];
  longint rec_p [0:1023];
  int     cyc = 0;
  int     last_flush = -1;
  longint f_sum = 0;
  int     f_cnt = 0;
  longint e_sum = 0;
  logic   e_ovf = 1'b0;
  logic   e_sv = 1'b0;
  logic   e_busy = 1'b0;

  initial begin
    forever begin
      int t, s;
      @(posedge clk);
      t = cyc;
      cyc++;
      rec_v[t] = bus.in_valid;
      rec_l[t] = bus.in_last;
      rec_p[t] = longint'(a_in) * longint'(b_in);
      e_sv = 1'b0;
      if (!rst_n) begin
        last_flush = t;
        f_sum = 0;
        f_cnt = 0;
        e_sum = 0;
        e_ovf = 1'b0;
      end else if (bus.acc_clear) begin
        last_flush = t;
        f_sum = 0;
        f_cnt = 0;
      end else begin
        s = t - LAT;
        if (s >= 0 && s > last_flush && rec_v[s]) begin
          f_sum += rec_p[s];
          f_cnt++;
          if (rec_l[s] || f_cnt == LEN) begin
            e_sum = f_sum % MODV;
            e_ovf = (f_sum >= MODV);
            e_sv  = 1'b1;
            f_sum = 0;
            f_cnt = 0;
          end
        end
      end
      e_busy = (f_cnt > 0);
      for (int j = t - LAT + 1; j <= t; j++)
        if (j >= 0 && j > last_flush && rec_v[j]) e_busy = 1'b1;
      #1;
      chk("sum_valid", bus.sum_valid_o, e_sv);
      chk("sum", bus.sum_o, e_sum);
      chk("overflow", bus.overflow_o, e_ovf);
      chk("busy", bus.busy_o, e_busy);
      if (bus.sum_valid_o) pulses++;
    end
  end

  initial begin
    int p0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.acc_clear = 1'b0;
    a_in = 8'd0;
    b_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset sum", bus.sum_o, 0);
    chk("reset strobe", bus.sum_valid_o, 0);
    chk("reset busy", bus.busy_o, 0);
    rst_n = 1'b1;

    // Four-pair frame: 2+12+30+56
    p0 = pulses;
    drive(1, 0, 1, 2, 0);
    drive(1, 0, 3, 4, 0);
    drive(1, 0, 5, 6, 0);
    drive(1, 1, 7, 8, 0);
    idle(5);
    chk("t1 sum", bus.sum_o, 100);
    chk("t1 ovf", bus.overflow_o, 0);
    chk("t1 pulses", pulses - p0, 1);
    chk("t1 busy", bus.busy_o, 0);

    // Auto-terminate at LEN, then a fresh frame
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 1, 0);
    idle(5);
    chk("t2 sum len", bus.sum_o, 8);
    drive(1, 0, 2, 3, 0);
    drive(1, 1, 0, 0, 0);
    idle(5);
    chk("t2 sum next", bus.sum_o, 6);

    // Overflow: 2*65025 = 130050 -> 64514 with carry
    drive(1, 0, 255, 255, 0);
    drive(1, 1, 255, 255, 0);
    idle(5);
    chk("t3 sum", bus.sum_o, 64514);
    chk("t3 ovf", bus.overflow_o, 1);
    drive(1, 1, 1, 1, 0);
    idle(5);
    chk("t3 sum after", bus.sum_o, 1);
    chk("t3 ovf after", bus.overflow_o, 0);

    // Back-to-back single-pair frames
    p0 = pulses;
    drive(1, 1, 2, 2, 0);
    drive(1, 1, 3, 3, 0);
    idle(5);
    chk("t4 pulses", pulses - p0, 2);
    chk("t4 sum", bus.sum_o, 9);

    // Clear lands on the edge the second product arrives
    p0 = pulses;
    drive(1, 0, 10, 10, 0);
    drive(1, 0, 10, 10, 0);
    idle(2);
    drive(0, 0, 0, 0, 1);
    idle(4);
    chk("t5 pulses", pulses - p0, 0);
    chk("t5 sum held", bus.sum_o, 9);
    drive(1, 1, 4, 5, 0);
    idle(5);
    chk("t5 sum", bus.sum_o, 20);

    // Asynchronous reset with two pairs in flight
    drive(1, 0, 3, 3, 0);
    drive(1, 0, 3, 3, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t6 busy before", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 sum", bus.sum_o, 0);
    chk("t6 busy", bus.busy_o, 0);
    chk("t6 strobe", bus.sum_valid_o, 0);
    chk("t6 ovf", bus.overflow_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 6, 7, 0);
    idle(5);
    chk("t6 sum after", bus.sum_o, 42);
    chk("t6 ovf after", bus.overflow_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
